// File: rtl/frame_sig_capture.sv
// Frame-signature unit: snoops the rendered pixel stream and produces per-channel CRC-16,
// a pixel count and a frame number over a programmable window, with valid/ack handoff.
module frame_sig_capture #(
    parameter int unsigned CH_W = 4,
    parameter int unsigned N_CH = 3,
    parameter int unsigned X_W  = 10,
    parameter int unsigned Y_W  = 10
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   pix_en_i,
    input  logic                   vs_i,
    input  logic                   de_i,
    input  logic [X_W-1:0]         draw_x_i,
    input  logic [Y_W-1:0]         draw_y_i,
    input  logic [N_CH*CH_W-1:0]   pix_i,
    input  logic [X_W-1:0]         win_x0_i,
    input  logic [X_W-1:0]         win_x1_i,
    input  logic [Y_W-1:0]         win_y0_i,
    input  logic [Y_W-1:0]         win_y1_i,
    input  logic                   arm_i,
    input  logic                   continuous_i,
    output logic                   sig_valid_o,
    input  logic                   sig_ack_i,
    output logic [N_CH*16-1:0]     sig_o,
    output logic [X_W+Y_W-1:0]     sig_pix_count_o,
    output logic [15:0]            sig_frame_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    localparam int unsigned CntW = X_W + Y_W;
    localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StWaitVs, StAccum} state_e;

    state_e                state_q;
    logic                  vs_q;
    logic [N_CH*16-1:0]    crc_q;
    logic [N_CH*16-1:0]    crc_d;
    logic [CntW-1:0]       cnt_q;
    logic [15:0]           frame_cnt_q;
    logic [N_CH*16-1:0]    sig_q;
    logic [CntW-1:0]       sig_cnt_q;
    logic [15:0]           sig_frame_q;
    logic                  sig_valid_q;
    logic                  busy_q;
    logic                  overrun_q;

    logic                  boundary;
    logic                  in_win;
    logic                  complete;
    logic                  accept;

    // CRC-16/CCITT step unrolled over CH_W data bits, MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc_in,
                                             input logic [CH_W-1:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = CH_W - 1; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    always_comb begin
        crc_d = crc_q;
        for (int k = 0; k < int'(N_CH); k++) begin
            crc_d[k*16 +: 16] = crc_step(crc_q[k*16 +: 16], pix_i[k*CH_W +: CH_W]);
        end
    end

    assign boundary = pix_en_i & vs_q & ~vs_i;
    assign in_win   = (draw_x_i >= win_x0_i) && (draw_x_i <= win_x1_i) &&
                      (draw_y_i >= win_y0_i) && (draw_y_i <= win_y1_i);
    assign complete = (state_q == StAccum) & boundary;
    assign accept   = complete & (~sig_valid_q | sig_ack_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            vs_q        <= 1'b1;
            crc_q       <= '1;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            sig_q       <= '0;
            sig_cnt_q   <= '0;
            sig_frame_q <= '0;
            sig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (pix_en_i) begin
                vs_q <= vs_i;
            end
            if (sig_ack_i) begin
                sig_valid_q <= 1'b0;
            end
            // Dropped frames still advance the frame number.
            if (complete) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (accept) begin
                    sig_q       <= crc_q;
                    sig_cnt_q   <= cnt_q;
                    sig_frame_q <= frame_cnt_q;
                    sig_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
            case (state_q)
                StIdle: begin
                    if (arm_i) begin
                        state_q <= StWaitVs;
                        busy_q  <= 1'b1;
                    end
                end
                StWaitVs: begin
                    if (boundary) begin
                        state_q <= StAccum;
                        crc_q   <= '1;
                        cnt_q   <= '0;
                    end
                end
                StAccum: begin
                    if (boundary) begin
                        crc_q <= '1;
                        cnt_q <= '0;
                        if (!continuous_i) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else if (pix_en_i && de_i && in_win) begin
                        crc_q <= crc_d;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CntOne;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sig_valid_o     = sig_valid_q;
    assign sig_o           = sig_q;
    assign sig_pix_count_o = sig_cnt_q;
    assign sig_frame_o     = sig_frame_q;
    assign busy_o          = busy_q;
    assign overrun_o       = overrun_q;

endmodule
